// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART TX block: address/data/strobes in, combinational read data out.
interface uart_tx_mmio_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (output Address, Write_data, MemRead, MemWrite, input Read_data);
  modport slave  (input Address, Write_data, MemRead, MemWrite, output Read_data);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO; UART_TX_IRQ_EN adds CTRL (0x8) and irq.
// tx falls 2 clk after a TXDATA store when idle; stores to a full FIFO drop the byte and set sticky ovf.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          BAUD_DIV   = 5208,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
`ifdef UART_TX_IRQ_EN
  output logic          irq,
`endif
  output logic          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [15:0]     baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            arm;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic            hit, empty, full, busy, baud_done;
  logic            push_req, push, pop, ovf_clr;
  logic [1:0]      off;
  logic [7:0]      head;
  logic [31:0]     status;
  logic            unused;

  assign hit       = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.Address[3:2];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign busy      = (state != IDLE);
  assign baud_done = (baud == '0);
  assign head      = mem[rd_ptr];
  assign unused    = ^{bus.Address[1:0], bus.Write_data[31:8]};

  // The serializer pops only from IDLE (one clock after it sees data) or at the end of a stop bit.
  assign pop      = (((state == IDLE) && arm) || ((state == STOP) && baud_done)) && !empty;
  assign push_req = bus.MemWrite && hit && (off == 2'd0);
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = bus.MemWrite && hit && (off == 2'd1) && bus.Write_data[3];
  assign status   = {19'd0, 9'(cnt), ovf, empty, full, busy};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.Write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A new overflow wins over a clear on the same edge.
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      arm     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          arm <= !empty;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
            shift <= head;
            baud  <= BAUD_LOAD;
            arm   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= '0;
            baud    <= BAUD_LOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= BAUD_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          if (baud_done) begin
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
              shift <= head;
              baud  <= BAUD_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (bus.MemWrite && hit && (off == 2'd2)) ie <= bus.Write_data[0];
      irq <= ie && empty && !busy;
    end
  end
`endif

  always_comb begin
    bus.Read_data = 32'h0;
    if (bus.MemRead && hit) begin
      case (off)
        2'd1:    bus.Read_data = status;
`ifdef UART_TX_IRQ_EN
        2'd2:    bus.Read_data = {31'd0, ie};
`endif
        default: bus.Read_data = 32'h0;
      endcase
    end
  end

endmodule
